// File: rtl/verific_parser_off_moore_seq_tx.sv
// verific_parser_off_moore_seq_tx
//   Serial frame transmitter driven by a Moore FSM.
//   Each frame is a 1011 preamble, then 8 data bits MSB first, then an
//   optional even-parity bit, then GAP_LEN idle zeros.
//   All outputs are decoded from registered state, counter and shift register.
//
// Optional feature macro: SEQ_TX_PARITY_EN
//   When it is defined, the frame has one PARITY cycle after DATA.
//
// Parameters
//   GAP_LEN      number of idle-zero cycles after each frame. Values outside
//                1..15 are clamped to that range.
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   data_valid   data_in holds a byte to transmit
//   data_in      payload byte, captured on acceptance
//   data_ready   high in IDLE only; acceptance = data_valid & data_ready
//   sequence_out serial bit stream
//   busy         frame in progress (state != IDLE)
//   tx_done      one-cycle pulse on the final GAP cycle
module verific_parser_off_moore_seq_tx #(
  parameter int GAP_LEN = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       data_ready,
  output logic       sequence_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int         GAP_EFF  = (GAP_LEN < 1) ? 1 : (GAP_LEN > 15) ? 15 : GAP_LEN;
  localparam logic [3:0] GAP_LAST = 4'(GAP_EFF - 1);
  localparam logic [3:0] PRE_PAT  = 4'b1011;

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, PREAMBLE = 3'd1, DATA = 3'd2, PARITY = 3'd3, GAP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, PREAMBLE = 3'd1, DATA = 3'd2, GAP = 3'd4
  } state_t;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt;    // cycle index within the current state
  logic [7:0] shreg;  // payload; bit 7 is the bit on the line during DATA
`ifdef SEQ_TX_PARITY_EN
  logic       par;    // even parity of the captured byte
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Illegal encodings fall to the default arm and go to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (data_valid)      state_nxt = PREAMBLE;
      PREAMBLE: if (cnt == 4'd3)     state_nxt = DATA;
`ifdef SEQ_TX_PARITY_EN
      DATA:     if (cnt == 4'd7)     state_nxt = PARITY;
      PARITY:                        state_nxt = GAP;
`else
      DATA:     if (cnt == 4'd7)     state_nxt = GAP;
`endif
      // >= so that a corrupted counter value cannot hold the FSM in GAP
      GAP:      if (cnt >= GAP_LAST) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Counter and payload. The counter restarts on every state change, so each
  // state sees indices 0..N-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      shreg <= '0;
`ifdef SEQ_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + 4'd1;

      if (state == IDLE && data_valid) begin
        shreg <= data_in;
`ifdef SEQ_TX_PARITY_EN
        par   <= ^data_in;
`endif
      end else if (state == DATA) begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  // Output decode (Moore): depends only on state, cnt, shreg and par
  always_comb begin
    data_ready   = 1'b0;
    busy         = 1'b1;
    sequence_out = 1'b0;
    tx_done      = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        busy       = 1'b0;
      end
      PREAMBLE: sequence_out = PRE_PAT[2'd3 - cnt[1:0]];
      DATA:     sequence_out = shreg[7];
`ifdef SEQ_TX_PARITY_EN
      PARITY:   sequence_out = par;
`endif
      GAP:      tx_done      = (cnt == GAP_LAST);
      default:  busy         = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_verific_parser_off_moore_seq_tx.sv
module tb_verific_parser_off_moore_seq_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] din;
  logic       rdy, so, bsy, done;

  // Two extra instances that check GAP_LEN clamping (0 -> 1, 20 -> 15)
  logic [1:0] cv;
  logic [1:0] crdy, cso, cbsy, cdone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  verific_parser_off_moore_seq_tx #(.GAP_LEN(2)) dut (
    .clock(clk), .reset(rst), .data_valid(dv), .data_in(din),
    .data_ready(rdy), .sequence_out(so), .busy(bsy), .tx_done(done));

  verific_parser_off_moore_seq_tx #(.GAP_LEN(0)) u_lo (
    .clock(clk), .reset(rst), .data_valid(cv[0]), .data_in(8'h55),
    .data_ready(crdy[0]), .sequence_out(cso[0]), .busy(cbsy[0]), .tx_done(cdone[0]));

  verific_parser_off_moore_seq_tx #(.GAP_LEN(20)) u_hi (
    .clock(clk), .reset(rst), .data_valid(cv[1]), .data_in(8'h55),
    .data_ready(crdy[1]), .sequence_out(cso[1]), .busy(cbsy[1]), .tx_done(cdone[1]));

  // Reference 1011 Moore detector watching sequence_out
  logic [3:0] hist;
  int         det_cnt;
  logic       det_en;
  always @(negedge clk) begin
    if (det_en) begin
      hist = {hist[2:0], so};
      if (hist == 4'b1011) det_cnt++;
    end
  end

  typedef struct {
    logic       rst, dv;
    logic [7:0] din;
    logic       seq, bsy, rdy, done;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic s, input logic b, input logic y, input logic t);
    vec_t e;
    e.rst = r; e.dv = v; e.din = d; e.seq = s; e.bsy = b; e.rdy = y; e.done = t;
    vecs.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!rdy && k < 60) begin
      tick;
      k++;
    end
    check({name, " idle-timeout"}, int'(rdy), 1);
  endtask

  task automatic do_reset;
    rst = 1'b1; dv = 1'b0; din = 8'h00; cv = 2'b00;
    tick; tick;
    rst = 1'b0;
  endtask

  logic [26:0] exp_b2b;
  logic [12:0] exp_par;
  int          first_rdy [2];

  initial begin
    rst = 1'b1; dv = 1'b0; din = 8'h00; cv = 2'b00;
    det_en = 1'b0; hist = 4'h0; det_cnt = 0;

    // reset state, abandoned 0xFF frame, reset mid-DATA, then 0xA5 frame
    add(1,0,8'h00, 0,0,1,0);
    add(0,1,8'hFF, 1,1,0,0);   // PRE0
    add(0,0,8'h00, 0,1,0,0);   // PRE1
    add(0,0,8'h00, 1,1,0,0);   // PRE2
    add(0,0,8'h00, 1,1,0,0);   // PRE3
    add(0,0,8'h00, 1,1,0,0);   // DATA bit7
    add(0,0,8'h00, 1,1,0,0);   // DATA bit6
    add(1,1,8'hFF, 0,0,1,0);   // reset edge: no acceptance
    add(0,1,8'hA5, 1,1,0,0);   // accept at T, T+1 = PRE0
    add(0,1,8'h00, 0,1,0,0);
    add(0,1,8'h00, 1,1,0,0);
    add(0,1,8'h00, 1,1,0,0);
    add(0,1,8'h00, 1,1,0,0);   // A5 = 1010_0101
    add(0,1,8'h00, 0,1,0,0);
    add(0,1,8'h00, 1,1,0,0);
    add(0,1,8'h00, 0,1,0,0);
    add(0,1,8'h00, 0,1,0,0);
    add(0,1,8'h00, 1,1,0,0);
    add(0,1,8'h00, 0,1,0,0);
    add(0,1,8'h00, 1,1,0,0);
    add(0,1,8'h00, 0,1,0,0);   // GAP0
    add(0,1,8'h00, 0,1,0,1);   // GAP1, T+14: tx_done
    add(0,1,8'h00, 0,0,1,0);   // T+15: IDLE
    add(0,0,8'h00, 0,0,1,0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; dv = vecs[i].dv; din = vecs[i].din;
      tick;
      check($sformatf("vec%0d seq", i),  int'(so),   int'(vecs[i].seq));
      check($sformatf("vec%0d busy", i), int'(bsy),  int'(vecs[i].bsy));
      check($sformatf("vec%0d rdy", i),  int'(rdy),  int'(vecs[i].rdy));
      check($sformatf("vec%0d done", i), int'(done), int'(vecs[i].done));
    end

    // Back-to-back 0x3C then 0xFF; data_in forced to 0 after the 2nd accept
    do_reset;
    exp_b2b = {4'b1011, 8'h3C, 3'b000, 4'b1011, 8'hFF};
    dv = 1'b1; din = 8'h3C;
    tick;
    din = 8'hFF;
    for (int k = 1; k <= 27; k++) begin
      if (k > 1) tick;
      check($sformatf("b2b bit T+%0d", k), int'(so), int'(exp_b2b[27-k]));
      if (k == 15) check("b2b rdy T+15", int'(rdy), 1);
      if (k == 16) begin dv = 1'b0; din = 8'h00; end
    end
    wait_idle("b2b");

    // Reset during PREAMBLE cycle 2: frame abandoned, no tx_done
    do_reset;
    dv = 1'b1; din = 8'h5A;
    tick;
    dv = 1'b0;
    tick;
    check("pre2 seq", int'(so), 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst-pre seq",  int'(so),  0);
    check("rst-pre busy", int'(bsy), 0);
    check("rst-pre rdy",  int'(rdy), 1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        if (done || bsy) seen++;
        tick;
      end
      check("rst-pre no activity", seen, 0);
    end

    // Detector fires once per frame: two back-to-back 0x00 frames
    do_reset;
    hist = 4'h0; det_cnt = 0; det_en = 1'b1;
    dv = 1'b1; din = 8'h00;
    tick;
    for (int k = 2; k <= 16; k++) tick;
    dv = 1'b0;
    for (int k = 0; k < 20; k++) tick;
    det_en = 1'b0;
    check("detector fires", det_cnt, 2);

`ifdef SEQ_TX_PARITY_EN
    // Parity frame for 0x07: 1011 00000111 1, tx_done at T+15
    do_reset;
    exp_par = {4'b1011, 8'h07, 1'b1};
    dv = 1'b1; din = 8'h07;
    tick;
    dv = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick;
      if (k <= 13) check($sformatf("par bit T+%0d", k), int'(so), int'(exp_par[13-k]));
      check($sformatf("par done T+%0d", k), int'(done), (k == 15) ? 1 : 0);
    end
    wait_idle("par");
`endif

    // GAP_LEN clamping: IDLE returns at T+13+clamped gap (+1 with parity)
    do_reset;
    cv = 2'b11;
    tick;
    cv = 2'b00;
    first_rdy[0] = 0; first_rdy[1] = 0;
    for (int k = 1; k <= 40; k++) begin
      for (int j = 0; j < 2; j++)
        if (crdy[j] && first_rdy[j] == 0) first_rdy[j] = k;
      tick;
    end
`ifdef SEQ_TX_PARITY_EN
    check("clamp lo ready", first_rdy[0], 15);
    check("clamp hi ready", first_rdy[1], 29);
`else
    check("clamp lo ready", first_rdy[0], 14);
    check("clamp hi ready", first_rdy[1], 28);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
